gcd: RTL and testbench
======================

GCD -- requirements
Module: gcd

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set operand and result bit width.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset, sampled on rising clk.
REQ-004 a  input  WIDTH  SHALL be the first unsigned operand, held level by the driver.
REQ-005 b  input  WIDTH  SHALL be the second unsigned operand, held level by the driver.
REQ-006 gcd_val  output  WIDTH  SHALL be the registered greatest common divisor of the last completed operand pair.

Function
REQ-007 The block SHALL implement a two-state FSM: IDLE (result valid, watching inputs) and CALC (iterating).
REQ-008 The block SHALL hold captured operand registers a_q, b_q and working registers x, y, each WIDTH bits.
REQ-009 In IDLE, if {a,b} differs from {a_q,b_q}, the block SHALL load a_q/x from a and b_q/y from b, then enter CALC at the next edge.
REQ-010 In IDLE with unchanged inputs, the block SHALL hold all registers.
REQ-011 In CALC, each edge SHALL apply the first matching rule:
- x==0: gcd_val<=y, go to IDLE.
- y==0: gcd_val<=x, go to IDLE.
- x==y: gcd_val<=x, go to IDLE.
- x>y: x<=x-y.
- otherwise: y<=y-x.
REQ-012 Subtraction SHALL be unsigned WIDTH-bit and SHALL never underflow, because only the larger value is reduced.
REQ-013 If {a,b} differs from {a_q,b_q} during CALC, the block SHALL abort the computation, reload from a and b, and stay in CALC; gcd_val SHALL keep its previous value.
REQ-014 gcd_val SHALL change only on completion and SHALL otherwise hold the last result.
REQ-015 Boundary results SHALL be: gcd(0,0)=0 and gcd(n,0)=gcd(0,n)=n.
REQ-016 Latency from an input change to the gcd_val update SHALL be 1 load edge + k subtraction edges + 1 completion edge, where k is the subtraction count; the worst case SHALL be at most 2^WIDTH+1 edges.

Reset
REQ-017 When reset==0 at a rising edge, the block SHALL set state=IDLE and set gcd_val, a_q, b_q, x and y to 0.
REQ-018 Reset SHALL take priority over every other rule, including mid-CALC; an aborted computation SHALL produce no result.
REQ-019 After reset is released with a=b=0, the block SHALL remain in IDLE with gcd_val=0.

Structure
REQ-020 A shared package gcd_pkg SHALL hold the FSM state encoding (IDLE, CALC) and the default WIDTH constant.
REQ-021 A single sub-module gcd_datapath SHALL contain the x/y registers, comparator and subtractors; gcd SHALL contain the FSM, the operand-change detector and the gcd_val register.

Verification
REQ-022 Reset: hold reset=0 for 2 edges with a=b=0 -> gcd_val=0 and state IDLE; after release, gcd_val stays 0.
REQ-023 Directed pairs: a=8,b=4 -> gcd_val=4 after 3 edges; a=2,b=2 -> 2 after 2 edges; a=14,b=4 -> 2 after 6 edges; a=10,b=9 -> 1 after 11 edges; gcd_val holds its previous value until each update.
REQ-024 Zero operands: a=0,b=6 -> 6; a=5,b=0 -> 5; a=0,b=0 -> 0.
REQ-025 Abort: apply a=15,b=1, then change to a=12,b=8 after 3 edges -> no intermediate result; gcd_val becomes 4.
REQ-026 Reset mid-CALC: apply a=15,b=1, assert reset after 4 edges -> gcd_val=0; after release, a new input change computes correctly.
REQ-027 Exhaustive: all 256 (a,b) pairs at WIDTH=4, each waiting 18 edges -> gcd_val matches a reference GCD model.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the iterative subtractive GCD engine.
package gcd_pkg;

   localparam int unsigned GCD_WIDTH = 4;

   typedef enum logic {
      StIdle = 1'b0,
      StCalc = 1'b1
   } state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Working registers x/y with the compare/subtract step of the subtractive GCD.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = GCD_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             w_x_zero;
   logic             w_y_zero;
   logic             w_eq;
   logic             w_gt;

   always_comb begin
      w_x_zero = (r_x == '0);
      w_y_zero = (r_y == '0);
      w_eq     = (r_x == r_y);
      w_gt     = (r_x > r_y);
      o_done   = w_x_zero | w_y_zero | w_eq;
      // x==0 yields y; y==0 and x==y both yield x.
      o_result = w_x_zero ? r_y : r_x;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_load) begin
         r_x <= i_a;
         r_y <= i_b;
      end else if (i_step) begin
         if (w_gt) begin
            r_x <= r_x - r_y;
         end else begin
            r_y <= r_y - r_x;
         end
      end
   end

endmodule

// File: rtl/gcd.sv
// GCD top: operand-change detector, IDLE/CALC control FSM and the result register.
module gcd
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = GCD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] gcd_val
);

   state_e           r_state;
   state_e           w_state_d;
   logic [WIDTH-1:0] r_a_q;
   logic [WIDTH-1:0] r_b_q;
   logic [WIDTH-1:0] r_gcd_val;
   logic             w_changed;
   logic             w_load;
   logic             w_step;
   logic             w_complete;
   logic             w_done;
   logic [WIDTH-1:0] w_result;

   assign w_changed = ({a, b} != {r_a_q, r_b_q});
   assign gcd_val   = r_gcd_val;

   always_comb begin
      w_state_d  = r_state;
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_changed) begin
               w_load    = 1'b1;
               w_state_d = StCalc;
            end
         end
         StCalc: begin
            // A new operand pair aborts the running computation without a result.
            if (w_changed) begin
               w_load = 1'b1;
            end else if (w_done) begin
               w_complete = 1'b1;
               w_state_d  = StIdle;
            end else begin
               w_step = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_a_q     <= '0;
         r_b_q     <= '0;
         r_gcd_val <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_load) begin
            r_a_q <= a;
            r_b_q <= b;
         end
         if (w_complete) begin
            r_gcd_val <= w_result;
         end
      end
   end

   gcd_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .i_clk    (clk),
      .i_rst_n  (reset),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_a      (a),
      .i_b      (b),
      .o_done   (w_done),
      .o_result (w_result)
   );

endmodule

// File: tb/tb_gcd.sv
// Directed and exhaustive self-checking bench for the gcd block at WIDTH=4.
module tb_gcd;
   import gcd_pkg::*;

   localparam int unsigned W = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] gcd_val;

   int checks   = 0;
   int failures = 0;

   gcd #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .gcd_val (gcd_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   initial begin
      reset = 1'b0;
      a     = '0;
      b     = '0;

      // Reset and release with zero operands.
      step(2);
      check("reset_gcd", int'(gcd_val), 0);
      check("reset_state", int'(dut.r_state), int'(StIdle));
      reset = 1'b1;
      step(3);
      check("post_reset_gcd", int'(gcd_val), 0);
      check("post_reset_state", int'(dut.r_state), int'(StIdle));

      // 8,4 -> 4 after 3 edges.
      a = 4'd8; b = 4'd4;
      step(2);
      check("p8_4_hold", int'(gcd_val), 0);
      check("p8_4_busy", int'(dut.r_state), int'(StCalc));
      step(1);
      check("p8_4_res", int'(gcd_val), 4);
      check("p8_4_idle", int'(dut.r_state), int'(StIdle));

      // 2,2 -> 2 after 2 edges.
      a = 4'd2; b = 4'd2;
      step(1);
      check("p2_2_hold", int'(gcd_val), 4);
      step(1);
      check("p2_2_res", int'(gcd_val), 2);

      // 14,4 -> 2 after 6 edges.
      a = 4'd14; b = 4'd4;
      step(5);
      check("p14_4_busy", int'(dut.r_state), int'(StCalc));
      step(1);
      check("p14_4_res", int'(gcd_val), 2);
      check("p14_4_idle", int'(dut.r_state), int'(StIdle));

      // 10,9 -> 1 after 11 edges.
      a = 4'd10; b = 4'd9;
      step(10);
      check("p10_9_hold", int'(gcd_val), 2);
      check("p10_9_busy", int'(dut.r_state), int'(StCalc));
      step(1);
      check("p10_9_res", int'(gcd_val), 1);

      // Zero operands.
      a = 4'd0; b = 4'd6;
      step(1);
      check("p0_6_hold", int'(gcd_val), 1);
      step(1);
      check("p0_6_res", int'(gcd_val), 6);
      a = 4'd5; b = 4'd0;
      step(2);
      check("p5_0_res", int'(gcd_val), 5);
      a = 4'd0; b = 4'd0;
      step(2);
      check("p0_0_res", int'(gcd_val), 0);

      // Abort: 15,1 replaced by 12,8 after 3 edges; only 4 may appear.
      a = 4'd15; b = 4'd1;
      step(3);
      check("abort_hold_a", int'(gcd_val), 0);
      a = 4'd12; b = 4'd8;
      step(3);
      check("abort_hold_b", int'(gcd_val), 0);
      check("abort_busy", int'(dut.r_state), int'(StCalc));
      step(1);
      check("abort_res", int'(gcd_val), 4);

      // Reset in the middle of a computation.
      a = 4'd15; b = 4'd1;
      step(4);
      check("rst_mid_hold", int'(gcd_val), 4);
      reset = 1'b0;
      step(1);
      check("rst_mid_gcd", int'(gcd_val), 0);
      check("rst_mid_state", int'(dut.r_state), int'(StIdle));
      reset = 1'b1;
      a = 4'd9; b = 4'd6;
      step(3);
      check("rst_after_hold", int'(gcd_val), 0);
      step(1);
      check("rst_after_res", int'(gcd_val), 3);

      // Exhaustive sweep against the reference model.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a = W'(i);
            b = W'(j);
            step(18);
            check($sformatf("ex_%0d_%0d", i, j), int'(gcd_val), ref_gcd(i, j));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
